wb_commit_queue: RTL and testbench
==================================

# wb_commit_queue

Writeback commit queue between the EX/MEM result producers and the register file's write port. It accepts up to two results per cycle (MEM-stage and ALU-stage), buffers them in program order in a small FIFO, and retires exactly one per cycle. Each retirement drives the register file's `reg_write_en`/`rd_addr`/`rd_data` and `clear_busy_addr` together. It also counts `reg_write_complete` acknowledgements for retirement bookkeeping.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `ADDR_WIDTH`, 5: register address width
- `DATA_WIDTH`, 64: result data width
- `clk  in  1  clock`
- `reset  in  1  asynchronous, active-low reset`
- `mem_valid  in  1  MEM-stage result valid`
- `mem_rd  in  ADDR_WIDTH  MEM destination register`
- `mem_data  in  DATA_WIDTH  MEM result`
- `mem_ready  out  1  MEM result accepted this cycle`
- `alu_valid  in  1  ALU-stage result valid`
- `alu_rd  in  ADDR_WIDTH  ALU destination register`
- `alu_data  in  DATA_WIDTH  ALU result`
- `alu_ready  out  1  ALU result accepted this cycle`
- `reg_write_en  out  1  register-file write strobe`
- `rd_addr  out  ADDR_WIDTH  write address`
- `rd_data  out  DATA_WIDTH  write data`
- `clear_busy_addr  out  ADDR_WIDTH  scoreboard clear address; 0 means none`
- `reg_write_complete  in  1  register-file write acknowledge`
- `commit_count  out  32  number of acknowledged writes`
- `empty  out  1  FIFO holds no entries`

## Operation
- **Producer handshake:** a transfer occurs when `valid && ready` at the rising edge. Producers hold `rd`/`data` stable while `valid && !ready`.
- **Readiness:** computed combinationally from the registered occupancy `count` only. Same-cycle pops do not create space.
  - `mem_ready = (count <= DEPTH-1)`
  - `alu_ready = mem_valid && mem_rd != 0 ? (count <= DEPTH-2) : (count <= DEPTH-1)`
- **Ordering:** MEM is older than ALU. When both transfer in the same cycle, the MEM entry is written first.
- **x0 results:** a result with `rd == 0` is accepted whenever its `ready` is high. It is discarded without occupying a slot, producing a write, or producing a clear.
- **Pop:** each cycle with `count > 0`, the head entry is popped at the edge and loaded into the output registers.
  - `reg_write_en = 1`, `rd_addr = rd_data's rd`, `rd_data = data`, `clear_busy_addr = rd` for exactly one cycle.
  - Otherwise `reg_write_en = 0` and `clear_busy_addr = 0`. `rd_addr`/`rd_data` hold their last values.
- **Counters:** `count_next = count + pushes − pop`, where pushes ∈ {0,1,2} and pop ∈ {0,1}. Read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
- **Commit counter:** `commit_count` increments on every cycle with `reg_write_complete = 1` and wraps from `2^32−1` to 0.
- **Reset (asynchronous, active-low):**
  - While `reset` is low, all state clears immediately: `count = 0`, pointers 0, `empty = 1`, `reg_write_en = 0`, `rd_addr = 0`, `rd_data = 0`, `clear_busy_addr = 0`, `commit_count = 0`.
  - During reset, `mem_ready` and `alu_ready` are 0.
  - Reset asserted mid-operation drops all queued entries. The scoreboard is reset in the same event.
  - Normal operation resumes on the first rising edge after `reset` goes high.

## Timing
- **Latency:** a result accepted at edge E appears on the write outputs after edge E+1. The register file commits it at edge E+2. `reg_write_complete` is expected high during the cycle after E+2.
- **Throughput:** 1 retirement per cycle. Sustained input of 2 per cycle fills the FIFO, then backpressures ALU first.
- **Full:** at `count == DEPTH`, both readies are low. They reassert the cycle after a pop.
- **Empty:** outputs idle the cycle after the last pop. No bypass from input to output.
- **Simultaneous events:** push and pop in the same cycle at `count == DEPTH-1` keep `count` unchanged. A `reg_write_complete` coinciding with any other event always counts.

## Structure
- **Package `wb_pkg`:** typedef `wb_entry_t` {`rd[ADDR_WIDTH-1:0]`, `data[DATA_WIDTH-1:0]`} and default constants for `WB_DEPTH`, `REG_ADDR_W`, `XLEN`.
- **Sub-module `wb_fifo`:** 2-write/1-read circular buffer holding the storage, pointers, and count. The top level holds the handshake, x0 filtering, output registers, and commit counter.

## Test plan
- **Single result:** reset, then one ALU result rd=5, data=0xDEAD at edge E.
  - Expect `reg_write_en = 1`, `rd_addr = 5`, `rd_data = 0xDEAD`, `clear_busy_addr = 5` for one cycle after E+1, then idle.
- **Dual push ordering:** MEM (rd=3, 0x33) and ALU (rd=4, 0x44) in the same cycle.
  - Expect writes x3 then x4 on consecutive cycles and `empty = 1` afterwards.
- **Fill and backpressure:** push 2 per cycle with `DEPTH = 4`.
  - Expect `alu_ready = 0` once `count ≥ 3` and `mem_ready = 0` at `count = 4`.
  - Expect no lost or duplicated entries and in-order writes of all accepted rd values.
- **x0 discard:** ALU rd=0, data=0xFF.
  - Expect `alu_ready = 1`, no write, `clear_busy_addr = 0`, and `count` unchanged.
- **Reset mid-operation:** queue 3 entries, then pull `reset` low between edges.
  - Expect immediate `reg_write_en = 0`, `empty = 1`, and `commit_count = 0`.
  - Expect no writes after release.
- **Commit counter:** pulse `reg_write_complete` 10 times, including pulses overlapping pushes and pops.
  - Expect `commit_count = 10`.
  - Preload near `2^32−1` and check wrap to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and default sizing for the writeback commit queue.
//   WB_DEPTH   - default number of queue entries
//   REG_ADDR_W - default register address width
//   XLEN       - default result data width
//   wb_entry_t - one queued writeback (destination register + data)
package wb_pkg;

    localparam int unsigned WB_DEPTH   = 4;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-write / 1-read circular buffer for writeback entries.
//   clk, reset   - clock, asynchronous active-low reset
//   wr0_en/data  - first (older) write this cycle
//   wr1_en/data  - second (younger) write; only used together with wr0
//   rd_en        - pop the head entry at the edge
//   rd_data      - current head entry (combinational)
//   count        - registered occupancy, 0..DEPTH
//   empty        - count == 0
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 69
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr0_en,
    input  logic [WIDTH-1:0]       wr0_data,
    input  logic                   wr1_en,
    input  logic [WIDTH-1:0]       wr1_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[wr_ptr] <= wr0_data;
        if (wr1_en) mem_q[wr_ptr + PW'(1)] <= wr1_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr0_en) + PW'(wr1_en);
            rd_ptr <= rd_ptr + PW'(rd_en);
            count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem_q[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: writeback commit queue between EX/MEM producers and the
// register file write port. Accepts up to two results per cycle (MEM older
// than ALU), retires one per cycle in program order.
//   clk, reset                   - clock, asynchronous active-low reset
//   mem_valid/mem_rd/mem_data    - MEM-stage result; mem_ready = accepted
//   alu_valid/alu_rd/alu_data    - ALU-stage result; alu_ready = accepted
//   reg_write_en/rd_addr/rd_data - registered register-file write
//   clear_busy_addr              - scoreboard clear address (0 = none)
//   reg_write_complete           - register-file write acknowledge
//   commit_count                 - count of acknowledges (wraps)
//   empty                        - queue holds no entries
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = WB_DEPTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    output logic                  reg_write_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] clear_busy_addr,
    input  logic                  reg_write_complete,
    output logic [31:0]           commit_count,
    output logic                  empty
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] LIM_ONE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM_TWO = CW'(DEPTH - 2);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [CW-1:0] count;
    logic          fifo_empty;
    entry_t        head;
    logic [EW-1:0] head_bits;
    logic          mem_push;
    logic          alu_push;
    logic          wr0_en;
    logic          wr1_en;
    entry_t        wr0_data;
    entry_t        wr1_data;
    logic          pop;
    logic [31:0]   commit_q;

    // Readiness depends only on registered occupancy; a same-cycle pop
    // never frees space. ALU needs two free slots when MEM really writes.
    always_comb begin
        mem_ready = 1'b0;
        alu_ready = 1'b0;
        if (reset) begin
            mem_ready = (count <= LIM_ONE);
            if (mem_valid && (mem_rd != '0))
                alu_ready = (count <= LIM_TWO);
            else
                alu_ready = (count <= LIM_ONE);
        end
    end

    // x0 results are accepted but never stored.
    assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

    // Compact the two producers onto the FIFO's ordered write lanes so
    // a lone ALU write lands in the next free slot.
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = '0;
        wr1_data = '0;
        if (mem_push) begin
            wr0_en   = 1'b1;
            wr0_data = '{rd: mem_rd, data: mem_data};
            wr1_en   = alu_push;
            wr1_data = '{rd: alu_rd, data: alu_data};
        end else if (alu_push) begin
            wr0_en   = 1'b1;
            wr0_data = '{rd: alu_rd, data: alu_data};
        end
    end

    assign pop = !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .rd_data  (head_bits),
        .count    (count),
        .empty    (fifo_empty)
    );

    assign head = head_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_en    <= 1'b0;
            rd_addr         <= '0;
            rd_data         <= '0;
            clear_busy_addr <= '0;
        end else begin
            reg_write_en    <= pop;
            clear_busy_addr <= pop ? head.rd : '0;
            if (pop) begin
                rd_addr <= head.rd;
                rd_data <= head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            commit_q <= '0;
        else if (reg_write_complete)
            commit_q <= commit_q + 32'd1;
    end

    assign commit_count = commit_q;
    assign empty        = fifo_empty;

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = REG_ADDR_W;
    localparam int unsigned DW    = XLEN;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_valid;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          reg_write_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] clear_busy_addr;
    logic          reg_write_complete;
    logic [31:0]   commit_count;
    logic          empty;

    wb_commit_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_valid          (mem_valid),
        .mem_rd             (mem_rd),
        .mem_data           (mem_data),
        .mem_ready          (mem_ready),
        .alu_valid          (alu_valid),
        .alu_rd             (alu_rd),
        .alu_data           (alu_data),
        .alu_ready          (alu_ready),
        .reg_write_en       (reg_write_en),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .clear_busy_addr    (clear_busy_addr),
        .reg_write_complete (reg_write_complete),
        .commit_count       (commit_count),
        .empty              (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: program-ordered queue of pending writebacks.
    wb_entry_t     q[$];
    logic [AW-1:0] last_rd;
    logic [DW-1:0] last_data;
    logic [31:0]   exp_commits;
    bit            mem_took;
    bit            alu_took;
    bit            alu_blocked_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_rd     = '0;
        last_data   = '0;
        exp_commits = '0;
    endtask

    task automatic idle_inputs();
        mem_valid          = 1'b0;
        mem_rd             = '0;
        mem_data           = '0;
        alu_valid          = 1'b0;
        alu_rd             = '0;
        alu_data           = '0;
        reg_write_complete = 1'b0;
    endtask

    // One clock: inputs already driven after a negedge; check readies,
    // advance the model across the edge, then check registered outputs.
    task automatic cycle();
        int        space;
        bit        exp_mr;
        bit        exp_ar;
        bit        do_pop;
        wb_entry_t head;
        #1;
        space  = int'(DEPTH) - q.size();
        exp_mr = (space >= 1);
        exp_ar = (mem_valid && mem_rd != '0) ? (space >= 2) : (space >= 1);
        chk("mem_ready", 64'(mem_ready), 64'(exp_mr));
        chk("alu_ready", 64'(alu_ready), 64'(exp_ar));
        if (alu_valid && !exp_ar) alu_blocked_seen = 1'b1;
        mem_took = mem_valid && exp_mr;
        alu_took = alu_valid && exp_ar;
        do_pop   = (q.size() > 0);
        head     = '0;
        if (do_pop) head = q[0];
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(q.pop_front());
            last_rd   = head.rd;
            last_data = head.data;
        end
        if (mem_took && mem_rd != '0) q.push_back('{rd: mem_rd, data: mem_data});
        if (alu_took && alu_rd != '0) q.push_back('{rd: alu_rd, data: alu_data});
        if (reg_write_complete) exp_commits = exp_commits + 32'd1;
        chk("reg_write_en", 64'(reg_write_en), 64'(do_pop));
        chk("rd_addr", 64'(rd_addr), 64'(last_rd));
        chk("rd_data", 64'(rd_data), 64'(last_data));
        chk("clear_busy_addr", 64'(clear_busy_addr), do_pop ? 64'(head.rd) : 64'd0);
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("commit_count", 64'(commit_count), 64'(exp_commits));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        idle_inputs();
        mem_took         = 1'b0;
        alu_took         = 1'b0;
        alu_blocked_seen = 1'b0;
        model_reset();

        // Reset state
        reset = 1'b0;
        #3;
        chk("rst_reg_write_en", 64'(reg_write_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_clear", 64'(clear_busy_addr), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_commit", 64'(commit_count), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single ALU result
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        cycle();
        idle_inputs();
        cycle();
        chk("single_write_addr", 64'(rd_addr), 64'd5);
        chk("single_write_data", 64'(rd_data), 64'hDEAD);
        cycle();
        chk("single_idle", 64'(reg_write_en), 64'd0);

        // Dual push ordering
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h33;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
        cycle();
        idle_inputs();
        cycle();
        chk("dual_first", 64'(rd_addr), 64'd3);
        cycle();
        chk("dual_second", 64'(rd_addr), 64'd4);
        cycle();
        chk("dual_empty", 64'(empty), 64'd1);

        // Fill and backpressure: two valid results every cycle
        for (int i = 0; i < 10; i++) begin
            if (!mem_valid || mem_took) begin
                mem_valid = 1'b1;
                mem_rd    = AW'(1 + (2 * i) % 31);
                mem_data  = 64'(i) | 64'h1000;
            end
            if (!alu_valid || alu_took) begin
                alu_valid = 1'b1;
                alu_rd    = AW'(2 + (2 * i) % 29);
                alu_data  = 64'(i) | 64'h2000;
            end
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) cycle();
        chk("alu_backpressure_seen", 64'(alu_blocked_seen), 64'd1);

        // x0 discard, alone and next to a real MEM result
        alu_valid = 1'b1; alu_rd = '0; alu_data = 64'hFF;
        cycle();
        idle_inputs();
        cycle();
        mem_valid = 1'b1; mem_rd = '0; mem_data = 64'h77;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Reset mid-operation
        reg_write_complete = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hB0;
        cycle();
        mem_rd = 5'd12; mem_data = 64'hC0;
        alu_rd = 5'd13; alu_data = 64'hD0;
        cycle();
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_reg_write_en", 64'(reg_write_en), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_commit", 64'(commit_count), 64'd0);
        chk("midrst_clear", 64'(clear_busy_addr), 64'd0);
        chk("midrst_mem_ready", 64'(mem_ready), 64'd0);
        chk("midrst_alu_ready", 64'(alu_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Commit counter: 10 pulses overlapping pushes and pops
        for (int i = 0; i < 14; i++) begin
            reg_write_complete = (i < 10);
            mem_valid = (i % 3 != 2);
            mem_rd    = AW'(i + 1);
            mem_data  = 64'(i) << 8;
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();
        chk("commit_ten", 64'(commit_count), 64'd10);

        // Wrap from 2^32-1 to 0
        force dut.commit_q = 32'hFFFF_FFFE;
        #1;
        release dut.commit_q;
        exp_commits = 32'hFFFF_FFFE;
        reg_write_complete = 1'b1;
        cycle();
        chk("commit_max", 64'(commit_count), 64'hFFFF_FFFF);
        cycle();
        chk("commit_wrap", 64'(commit_count), 64'd0);
        reg_write_complete = 1'b0;

        // Randomized traffic; producers hold values while not accepted
        mem_took = 1'b0;
        alu_took = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!mem_valid || mem_took) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
                mem_data  = {$urandom, $urandom};
            end
            if (!alu_valid || alu_took) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
                alu_data  = {$urandom, $urandom};
            end
            reg_write_complete = ($urandom_range(0, 1) == 1);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) cycle();
        chk("final_empty", 64'(empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
